temp_f_bcd_converter: RTL and testbench

Converts an 8-bit integer Celsius reading from the greenhouse sensor interface into the 10-bit packed-BCD Fahrenheit value consumed by the VGA display controller's `TEMP_F` input. The hundreds digit is 2 bits; tens and ones are 4 bits each. Conversion is multi-cycle: a start/busy/done handshake, a sequential divide-by-5 and a sequential double-dabble. The registered result holds until the next conversion completes.

---
 rtl/temp_f_bcd_converter.sv | 167 ++++++++++++++++
 tb/tb_temp_f_bcd_converter.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/temp_f_bcd_converter.sv
// temp_f_bcd_converter
// Converts an unsigned 8-bit Celsius reading into a 10-bit packed-BCD
// Fahrenheit value: F = floor((9*C + 2) / 5) + 32, clamped above 399.
// The divide-by-5 and the binary-to-BCD conversion are both done one bit
// per cycle. The whole conversion takes 24 cycles.
//
// Ports
//   CLOCK_50    in   1  system clock
//   RESET       in   1  synchronous, active-high reset
//   START       in   1  conversion request, only honoured while idle
//   TEMP_C      in   8  Celsius reading, captured when START is accepted
//   BUSY        out  1  conversion in progress (low again in the FIN cycle)
//   DONE        out  1  one-cycle pulse when TEMP_F / OVER_RANGE update
//   TEMP_F      out 10  BCD result {hundreds[1:0], tens[3:0], ones[3:0]}
//   OVER_RANGE  out  1  last result was clamped to CLAMP_BCD
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | waiting for START; outputs hold the last result
// DIV   | restoring divide of 9C+2 by 5, one quotient bit per cycle
// ADJ   | add 32, decide clamp, load double-dabble source
// BCD   | double-dabble, one source bit per cycle
// FIN   | publish result, pulse DONE

module temp_f_bcd_converter #(
    parameter logic [9:0] CLAMP_BCD = 10'h399
) (
    input  logic       CLOCK_50,
    input  logic       RESET,
    input  logic       START,
    input  logic [7:0] TEMP_C,
    output logic       BUSY,
    output logic       DONE,
    output logic [9:0] TEMP_F,
    output logic       OVER_RANGE
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DIV,
        S_ADJ,
        S_BCD,
        S_FIN
    } state_t;

    state_t      state_q;
    logic [11:0] num_q;
    logic [11:0] quo_q;
    logic [2:0]  rem_q;
    logic [3:0]  cnt_q;
    logic [8:0]  src_q;
    logic [11:0] scr_q;
    logic        clamp_q;
    logic        busy_q;
    logic        done_q;
    logic [9:0]  temp_f_q;
    logic        over_q;

    logic [11:0] num_d;
    logic [3:0]  trial_d;
    logic [3:0]  diff_d;
    logic        sub_ok_d;
    logic [2:0]  rem_d;
    logic [11:0] sum_d;
    logic        clamp_d;
    logic [11:0] scr_adj_d;
    logic [11:0] scr_shift_d;

    // 9*C + 2 without a multiplier
    assign num_d = ({4'd0, TEMP_C} << 3) + {4'd0, TEMP_C} + 12'd2;

    // Remainder never exceeds 4, so the trial value fits in 4 bits
    assign trial_d  = {rem_q, num_q[11]};
    assign diff_d   = trial_d - 4'd5;
    assign sub_ok_d = (trial_d >= 4'd5);
    assign rem_d    = sub_ok_d ? diff_d[2:0] : trial_d[2:0];

    assign sum_d   = quo_q + 12'd32;
    assign clamp_d = (sum_d > 12'd399);

    always_comb begin
        scr_adj_d = scr_q;
        for (int i = 0; i < 3; i++) begin
            if (scr_q[4*i +: 4] >= 4'd5) begin
                scr_adj_d[4*i +: 4] = scr_q[4*i +: 4] + 4'd3;
            end
        end
    end

    assign scr_shift_d = (scr_adj_d << 1) | {11'd0, src_q[8]};

    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            state_q  <= S_IDLE;
            num_q    <= '0;
            quo_q    <= '0;
            rem_q    <= '0;
            cnt_q    <= '0;
            src_q    <= '0;
            scr_q    <= '0;
            clamp_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            temp_f_q <= '0;
            over_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (START) begin
                        num_q   <= num_d;
                        quo_q   <= '0;
                        rem_q   <= '0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= S_DIV;
                    end
                end
                S_DIV: begin
                    rem_q <= rem_d;
                    quo_q <= {quo_q[10:0], sub_ok_d};
                    num_q <= num_q << 1;
                    if (cnt_q == 4'd11) begin
                        cnt_q   <= '0;
                        state_q <= S_ADJ;
                    end else begin
                        cnt_q <= cnt_q + 4'd1;
                    end
                end
                S_ADJ: begin
                    clamp_q <= clamp_d;
                    src_q   <= sum_d[8:0];
                    scr_q   <= '0;
                    cnt_q   <= '0;
                    state_q <= S_BCD;
                end
                S_BCD: begin
                    scr_q <= scr_shift_d;
                    src_q <= src_q << 1;
                    if (cnt_q == 4'd8) begin
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                        state_q <= S_FIN;
                    end else begin
                        cnt_q <= cnt_q + 4'd1;
                    end
                end
                S_FIN: begin
                    temp_f_q <= clamp_q ? CLAMP_BCD : scr_q[9:0];
                    over_q   <= clamp_q;
                    done_q   <= 1'b1;
                    state_q  <= S_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign BUSY       = busy_q;
    assign DONE       = done_q;
    assign TEMP_F     = temp_f_q;
    assign OVER_RANGE = over_q;

endmodule

// File: tb/tb_temp_f_bcd_converter.sv
module tb_temp_f_bcd_converter;

    logic       CLOCK_50 = 1'b0;
    logic       RESET    = 1'b1;
    logic       START    = 1'b0;
    logic [7:0] TEMP_C   = 8'd0;
    logic       BUSY;
    logic       DONE;
    logic [9:0] TEMP_F;
    logic       OVER_RANGE;

    temp_f_bcd_converter #(.CLAMP_BCD(10'h399)) dut (
        .CLOCK_50  (CLOCK_50),
        .RESET     (RESET),
        .START     (START),
        .TEMP_C    (TEMP_C),
        .BUSY      (BUSY),
        .DONE      (DONE),
        .TEMP_F    (TEMP_F),
        .OVER_RANGE(OVER_RANGE)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    // Reference conversion: returns {over_range, temp_f}
    function automatic logic [10:0] ref_conv(input int c);
        int s;
        s = (9 * c + 2) / 5 + 32;
        if (s > 399) return {1'b1, 10'h399};
        return {1'b0, 2'(s / 100), 4'((s / 10) % 10), 4'(s % 10)};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Timing model: cycles elapsed since START acceptance
    int         m_phase = 0;
    logic [7:0] m_cap   = 8'd0;
    logic       m_busy  = 1'b0;
    logic       m_done  = 1'b0;
    logic       m_ov    = 1'b0;
    logic [9:0] m_tf    = 10'd0;

    always @(posedge CLOCK_50) begin
        logic [10:0] r;
        if (RESET) begin
            m_phase = 0;
            m_busy  = 1'b0;
            m_done  = 1'b0;
            m_tf    = 10'd0;
            m_ov    = 1'b0;
        end else begin
            m_done = 1'b0;
            if (m_phase == 0) begin
                if (START) begin
                    m_phase = 1;
                    m_cap   = TEMP_C;
                    m_busy  = 1'b1;
                end
            end else begin
                m_phase++;
                if (m_phase == 23) m_busy = 1'b0;
                if (m_phase == 24) begin
                    r       = ref_conv(int'(m_cap));
                    m_tf    = r[9:0];
                    m_ov    = r[10];
                    m_done  = 1'b1;
                    m_phase = 0;
                end
            end
        end
    end

    always @(negedge CLOCK_50) begin
        if (chk_en) begin
            check("busy", 32'(BUSY), 32'(m_busy));
            check("done", 32'(DONE), 32'(m_done));
            check("temp_f", 32'(TEMP_F), 32'(m_tf));
            check("over_range", 32'(OVER_RANGE), 32'(m_ov));
        end
    end

    // Pulses START at the current negedge, returns negedges until DONE (40 = timeout)
    task automatic start_and_wait(input logic [7:0] c, output int n);
        START  = 1'b1;
        TEMP_C = c;
        n = 0;
        while (n < 40) begin
            @(negedge CLOCK_50);
            START  = 1'b0;
            TEMP_C = 8'($urandom);
            n++;
            if (DONE === 1'b1) break;
        end
    endtask

    task automatic run_conv(input logic [7:0] c, input logic [9:0] lit_tf,
                            input logic lit_ov, input bit use_lit);
        int n;
        logic [10:0] exp;
        @(negedge CLOCK_50);
        start_and_wait(c, n);
        check("latency", 32'(n), 32'd24);
        exp = ref_conv(int'(c));
        if (use_lit) begin
            check("model_pin", 32'(exp), 32'({lit_ov, lit_tf}));
            exp = {lit_ov, lit_tf};
        end
        check("result_tf", 32'(TEMP_F), 32'(exp[9:0]));
        check("result_ov", 32'(OVER_RANGE), 32'(exp[10]));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        int dcount;
        int dtimes[$];

        RESET = 1'b1;
        repeat (3) @(posedge CLOCK_50);
        chk_en = 1'b1;
        @(negedge CLOCK_50);
        check("reset_tf", 32'(TEMP_F), 32'h0);
        check("reset_busy", 32'(BUSY), 32'h0);
        check("reset_done", 32'(DONE), 32'h0);
        RESET = 1'b0;

        run_conv(8'd0,   10'h032, 1'b0, 1'b1);
        run_conv(8'd25,  10'h077, 1'b0, 1'b1);
        run_conv(8'd37,  10'h099, 1'b0, 1'b1);
        run_conv(8'd38,  10'h100, 1'b0, 1'b1);
        run_conv(8'd100, 10'h212, 1'b0, 1'b1);
        run_conv(8'd204, 10'h399, 1'b0, 1'b1);
        run_conv(8'd205, 10'h399, 1'b1, 1'b1);
        run_conv(8'd255, 10'h399, 1'b1, 1'b1);

        // START while busy is ignored
        @(negedge CLOCK_50);
        START  = 1'b1;
        TEMP_C = 8'd25;
        n = 0;
        while (n < 40) begin
            @(negedge CLOCK_50);
            n++;
            START = (n == 5);
            TEMP_C = (n == 5) ? 8'd100 : 8'd25;
            if (DONE === 1'b1) break;
        end
        START = 1'b0;
        check("busy_latency", 32'(n), 32'd24);
        check("busy_tf", 32'(TEMP_F), 32'h077);
        dcount = 0;
        repeat (30) begin
            @(negedge CLOCK_50);
            if (DONE === 1'b1) dcount++;
        end
        check("busy_extra_done", 32'(dcount), 32'd0);

        // START held high: back-to-back conversions
        @(negedge CLOCK_50);
        START = 1'b1;
        for (int i = 1; i <= 100; i++) begin
            TEMP_C = 8'($urandom);
            @(negedge CLOCK_50);
            if (DONE === 1'b1) dtimes.push_back(i);
        end
        START = 1'b0;
        check("b2b_count", 32'(dtimes.size()), 32'd4);
        for (int i = 1; i < dtimes.size(); i++)
            check("b2b_spacing", 32'(dtimes[i] - dtimes[i-1]), 32'd24);
        repeat (30) @(negedge CLOCK_50);

        // Reset mid-conversion
        START  = 1'b1;
        TEMP_C = 8'd100;
        repeat (10) begin
            @(negedge CLOCK_50);
            START = 1'b0;
        end
        RESET = 1'b1;
        @(negedge CLOCK_50);
        RESET = 1'b0;
        check("midrst_tf", 32'(TEMP_F), 32'h0);
        check("midrst_busy", 32'(BUSY), 32'h0);
        dcount = 0;
        repeat (30) begin
            @(negedge CLOCK_50);
            if (DONE === 1'b1) dcount++;
        end
        check("midrst_no_done", 32'(dcount), 32'd0);
        run_conv(8'd0, 10'h032, 1'b0, 1'b1);

        // Exhaustive sweep
        for (int c = 0; c < 256; c++) run_conv(8'(c), 10'h0, 1'b0, 1'b0);

        // Random START / TEMP_C / RESET traffic, checked cycle by cycle
        repeat (3000) begin
            @(negedge CLOCK_50);
            START  = ($urandom_range(0, 7) == 0);
            TEMP_C = 8'($urandom);
            RESET  = ($urandom_range(0, 199) == 0);
        end
        @(negedge CLOCK_50);
        START = 1'b0;
        RESET = 1'b0;
        repeat (30) @(negedge CLOCK_50);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
